// File: rtl/spi_xip_ctrl.sv
// Flash read sequencer: turns one 24-bit read request into an APB programme of the SPI master.
// Optional poll timeout is compiled in with `define SPI_XIP_TIMEOUT_EN.
module spi_xip_ctrl #(
   parameter logic [31:0] CTRL_WORD = 32'h0000_2140,
   parameter int          GO_BIT    = 8,
   parameter int          POLL_MAX  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [4:0]  PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic        PSEL,
   output logic        PENABLE,
   input  logic [31:0] PRDATA,
   input  logic        PREADY
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_TX1  = 3'd1;
   localparam logic [2:0] S_WR_TX0  = 3'd2;
   localparam logic [2:0] S_WR_CTRL = 3'd3;
   localparam logic [2:0] S_POLL    = 3'd4;
   localparam logic [2:0] S_RD_RX   = 3'd5;
   localparam logic [2:0] S_RESP    = 3'd6;

   localparam logic [4:0] ADDR_RX0  = 5'h00;
   localparam logic [4:0] ADDR_TX0  = 5'h00;
   localparam logic [4:0] ADDR_TX1  = 5'h04;
   localparam logic [4:0] ADDR_CTRL = 5'h10;
   localparam logic [7:0] CMD_READ  = 8'h03;

   if (GO_BIT < 0 || GO_BIT > 31 || POLL_MAX < 1) begin : g_bad_params
      $error("spi_xip_ctrl: GO_BIT must be 0..31 and POLL_MAX at least 1");
   end

   logic [2:0] state;
   logic       apb_done;
   logic       go_busy;
   logic       timeout_hit;

   assign apb_done  = PSEL & PENABLE & PREADY;
   assign go_busy   = PRDATA[GO_BIT];
   assign req_ready = (state == S_IDLE) & ~rst;

`ifdef SPI_XIP_TIMEOUT_EN
   localparam int CNT_W = ($clog2(POLL_MAX) > 8) ? $clog2(POLL_MAX) : 8;

   logic [CNT_W-1:0] poll_cnt;

   assign timeout_hit = (state == S_POLL) & apb_done & go_busy &
                        (poll_cnt == CNT_W'(POLL_MAX - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if ((state == S_WR_CTRL) && apb_done)
            poll_cnt <= '0;
         else if ((state == S_POLL) && apb_done)
            poll_cnt <= poll_cnt + 1'b1;
         if (timeout_hit)
            rsp_err <= 1'b1;
         else if ((state == S_RESP) && rsp_ready)
            rsp_err <= 1'b0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // Every APB transfer is launched as SETUP on the edge that completes the previous one,
   // so address/data/direction stay registered and stable for the whole access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (PSEL && !PENABLE)
            PENABLE <= 1'b1;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  state   <= S_WR_TX1;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
                  PWRITE  <= 1'b1;
                  PADDR   <= ADDR_TX1;
                  PWDATA  <= {CMD_READ, req_addr};
               end
            end
            S_WR_TX1: begin
               if (apb_done) begin
                  state   <= S_WR_TX0;
                  PENABLE <= 1'b0;
                  PADDR   <= ADDR_TX0;
                  PWDATA  <= '0;
               end
            end
            S_WR_TX0: begin
               if (apb_done) begin
                  state   <= S_WR_CTRL;
                  PENABLE <= 1'b0;
                  PADDR   <= ADDR_CTRL;
                  PWDATA  <= CTRL_WORD;
               end
            end
            S_WR_CTRL: begin
               if (apb_done) begin
                  state   <= S_POLL;
                  PENABLE <= 1'b0;
                  PWRITE  <= 1'b0;
                  PADDR   <= ADDR_CTRL;
                  PWDATA  <= '0;
               end
            end
            S_POLL: begin
               if (apb_done) begin
                  PENABLE <= 1'b0;
                  if (!go_busy) begin
                     state <= S_RD_RX;
                     PADDR <= ADDR_RX0;
                  end else if (timeout_hit) begin
                     state     <= S_RESP;
                     PSEL      <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_data  <= '0;
                  end
               end
            end
            S_RD_RX: begin
               if (apb_done) begin
                  state     <= S_RESP;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= PRDATA;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule
